// File: rtl/alu_pkg.sv
// alu_pkg: shared constants and types for the ALU status unit and branch unit.
//   ALU_ARITH_BIT / ALU_SUB_BIT : alucontrol bit positions (bit1=0 arithmetic, bit0=1 subtract)
//   FLAG_N/Z/C/V                 : bit positions inside the 4-bit {N,Z,C,V} flag word
//   cond_e                       : the 16 condition codes
package alu_pkg;

  localparam int ALU_ARITH_BIT = 1;
  localparam int ALU_SUB_BIT   = 0;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

endpackage

// File: rtl/alu_status_unit_cond_eval.sv
// cond_eval: combinational condition-code evaluator, shared with the branch unit.
//   flags_i [3:0] in  : {N,Z,C,V}
//   cond_i  cond_e in : condition code
//   pass_o        out : 1 when cond_i holds for flags_i
module cond_eval
  import alu_pkg::*;
(
  input  logic [3:0] flags_i,
  input  cond_e      cond_i,
  output logic       pass_o
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = flags_i[FLAG_N];
  assign w_z = flags_i[FLAG_Z];
  assign w_c = flags_i[FLAG_C];
  assign w_v = flags_i[FLAG_V];

  always_comb begin
    pass_o = 1'b0;
    case (cond_i)
      COND_EQ: pass_o = w_z;
      COND_NE: pass_o = ~w_z;
      COND_CS: pass_o = w_c;
      COND_CC: pass_o = ~w_c;
      COND_MI: pass_o = w_n;
      COND_PL: pass_o = ~w_n;
      COND_VS: pass_o = w_v;
      COND_VC: pass_o = ~w_v;
      COND_HI: pass_o = w_c & ~w_z;
      COND_LS: pass_o = ~w_c | w_z;
      COND_GE: pass_o = (w_n == w_v);
      COND_LT: pass_o = (w_n != w_v);
      COND_GT: pass_o = ~w_z & (w_n == w_v);
      COND_LE: pass_o = w_z | (w_n != w_v);
      COND_AL: pass_o = 1'b1;
      COND_NV: pass_o = 1'b1;
      default: pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_status_unit.sv
// alu_status_unit: registered NZCV flags, condition evaluation from the
// registered flags, sticky overflow bit and an optional saturating overflow counter.
//   Parameters: N operand width (>=2), CW overflow counter width (>=1)
//   clk, rst (sync, active-high)
//   a_i, b_i, result_i, carry_i, alucontrol : ALU datapath taps
//   valid_i & setflags_i                    : flag update strobe
//   cond_i / cond_pass_o                    : condition code and its result on flags_o
//   clr_sticky_i                            : clears sticky V and counter (a same-cycle set wins)
//   flags_o {N,Z,C,V}, sticky_v_o, ovf_count_o
// Build option: define ALU_OVF_COUNT_EN to build the counter; otherwise ovf_count_o is 0.
module alu_status_unit
  import alu_pkg::*;
#(
  parameter int N  = 32,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  a_i,
  input  logic [N-1:0]  b_i,
  input  logic [N-1:0]  result_i,
  input  logic          carry_i,
  input  logic [3:0]    alucontrol,
  input  logic          valid_i,
  input  logic          setflags_i,
  input  logic [3:0]    cond_i,
  input  logic          clr_sticky_i,
  output logic [3:0]    flags_o,
  output logic          cond_pass_o,
  output logic          sticky_v_o,
  output logic [CW-1:0] ovf_count_o
);

  logic [3:0] r_flags;
  logic       r_sticky_v;

  logic       w_upd;
  logic       w_arith;
  logic       w_n, w_z, w_c, w_v;
  logic       w_ovf_evt;

  assign w_upd   = valid_i & setflags_i;
  assign w_arith = ~alucontrol[ALU_ARITH_BIT];

  assign w_n = result_i[N-1];
  assign w_z = (result_i == '0);
  // Logic ops keep the previous C and V, so a held V=1 still counts as an overflow event.
  assign w_c = w_arith ? carry_i : r_flags[FLAG_C];
  assign w_v = w_arith ? (~(a_i[N-1] ^ b_i[N-1] ^ alucontrol[ALU_SUB_BIT]) & (result_i[N-1] ^ a_i[N-1]))
                       : r_flags[FLAG_V];

  assign w_ovf_evt = w_upd & w_v;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flags    <= 4'b0000;
      r_sticky_v <= 1'b0;
    end else begin
      if (w_upd) begin
        r_flags <= {w_n, w_z, w_c, w_v};
      end
      if (w_ovf_evt) begin
        r_sticky_v <= 1'b1;
      end else if (clr_sticky_i) begin
        r_sticky_v <= 1'b0;
      end
    end
  end

`ifdef ALU_OVF_COUNT_EN
  logic [CW-1:0] r_ovf_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf_count <= '0;
    end else if (clr_sticky_i) begin
      // Clear and a same-cycle event: the event is the first one after the clear.
      r_ovf_count <= w_ovf_evt ? CW'(1) : '0;
    end else if (w_ovf_evt && (r_ovf_count != {CW{1'b1}})) begin
      r_ovf_count <= r_ovf_count + CW'(1);
    end
  end

  assign ovf_count_o = r_ovf_count;
`else
  assign ovf_count_o = '0;
`endif

  assign flags_o    = r_flags;
  assign sticky_v_o = r_sticky_v;

  // Evaluated from the registered flags only; no forwarding of the in-flight result.
  cond_eval u_cond_eval (
    .flags_i (r_flags),
    .cond_i  (cond_e'(cond_i)),
    .pass_o  (cond_pass_o)
  );

endmodule

// File: tb/tb_alu_status_unit.sv
// tb_alu_status_unit: directed scenarios plus randomized traffic against a
// behavioural model of the NZCV status unit (N=8, CW=2).
module tb_alu_status_unit;
  import alu_pkg::*;

  localparam int N  = 8;
  localparam int CW = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  a_i, b_i, result_i;
  logic          carry_i;
  logic [3:0]    alucontrol;
  logic          valid_i, setflags_i;
  logic [3:0]    cond_i;
  logic          clr_sticky_i;
  logic [3:0]    flags_o;
  logic          cond_pass_o;
  logic          sticky_v_o;
  logic [CW-1:0] ovf_count_o;

  int n_checks = 0;
  int n_errors = 0;

  // model state
  bit m_n, m_z, m_c, m_v;
  bit m_sticky;
  int m_cnt;

  alu_status_unit #(.N(N), .CW(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .a_i          (a_i),
    .b_i          (b_i),
    .result_i     (result_i),
    .carry_i      (carry_i),
    .alucontrol   (alucontrol),
    .valid_i      (valid_i),
    .setflags_i   (setflags_i),
    .cond_i       (cond_i),
    .clr_sticky_i (clr_sticky_i),
    .flags_o      (flags_o),
    .cond_pass_o  (cond_pass_o),
    .sticky_v_o   (sticky_v_o),
    .ovf_count_o  (ovf_count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit ref_cond(input bit n, z, c, v, input int code);
    case (code)
      0:  return z;
      1:  return !z;
      2:  return c;
      3:  return !c;
      4:  return n;
      5:  return !n;
      6:  return v;
      7:  return !v;
      8:  return c && !z;
      9:  return !c || z;
      10: return n == v;
      11: return n != v;
      12: return !z && (n == v);
      13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  function automatic int exp_count();
`ifdef ALU_OVF_COUNT_EN
    return m_cnt;
`else
    return 0;
`endif
  endfunction

  // One clock: drive at negedge, check cond_pass on the current flags, then
  // check the registered state after the rising edge.
  task automatic step(input logic [7:0] a, input logic [7:0] b, input logic [7:0] lres,
                      input logic [3:0] ctl, input bit v, input bit s,
                      input logic [3:0] cond, input bit clr, input bit r);
    logic [7:0] res;
    bit carry, ovf, upd;
    int sa, sb, sr;
    @(negedge clk);
    sa = $signed(a);
    sb = $signed(b);
    if (!ctl[1]) begin
      if (ctl[0]) begin
        res = a - b;
        carry = (a >= b);
        sr = sa - sb;
      end else begin
        res = a + b;
        carry = (int'(a) + int'(b)) > 255;
        sr = sa + sb;
      end
      ovf = (sr > 127) || (sr < -128);
    end else begin
      res = lres;
      carry = 1'($urandom_range(0, 1));
      ovf = 1'b0;
    end
    rst = r; a_i = a; b_i = b; result_i = res; carry_i = carry; alucontrol = ctl;
    valid_i = v; setflags_i = s; cond_i = cond; clr_sticky_i = clr;
    #1;
    check("cond_pass", 32'(cond_pass_o), 32'(ref_cond(m_n, m_z, m_c, m_v, int'(cond))));
    upd = v && s;
    if (r) begin
      {m_n, m_z, m_c, m_v} = 4'b0000;
      m_sticky = 0;
      m_cnt = 0;
    end else begin
      if (upd) begin
        m_n = res[7];
        m_z = (res == 0);
        if (!ctl[1]) begin
          m_c = carry;
          m_v = ovf;
        end
      end
      if (clr) begin
        m_sticky = upd && m_v;
        m_cnt = (upd && m_v) ? 1 : 0;
      end else if (upd && m_v) begin
        m_sticky = 1;
        if (m_cnt < CNT_MAX) m_cnt++;
      end
    end
    @(posedge clk);
    #1;
    check("flags", 32'(flags_o), 32'({m_n, m_z, m_c, m_v}));
    check("sticky", 32'(sticky_v_o), 32'(m_sticky));
    check("count", 32'(ovf_count_o), 32'(exp_count()));
  endtask

  task automatic idle(input logic [3:0] cond);
    step(8'h00, 8'h00, 8'h00, 4'b0000, 1'b0, 1'b0, cond, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1; a_i = 0; b_i = 0; result_i = 0; carry_i = 0; alucontrol = 0;
    valid_i = 0; setflags_i = 0; cond_i = 0; clr_sticky_i = 0;
    m_n = 0; m_z = 0; m_c = 0; m_v = 0; m_sticky = 0; m_cnt = 0;

    // reset held 2 cycles while an overflowing update is presented: reset wins
    step(8'h7F, 8'h01, 8'h00, 4'b0000, 1'b1, 1'b1, 4'(COND_NE), 1'b0, 1'b1);
    step(8'h7F, 8'h01, 8'h00, 4'b0000, 1'b1, 1'b1, 4'(COND_NE), 1'b0, 1'b1);
    check("rst_flags", 32'(flags_o), 32'h0);
    idle(4'(COND_NE));
    check("rst_ne", 32'(cond_pass_o), 32'h1);
    idle(4'(COND_EQ));
    check("rst_eq", 32'(cond_pass_o), 32'h0);

    // ADD 0x7F + 0x01 -> 0x80, signed overflow; same-cycle VS sees old flags
    step(8'h7F, 8'h01, 8'h00, 4'b0000, 1'b1, 1'b1, 4'(COND_VS), 1'b0, 1'b0);
    check("add_flags", 32'(flags_o), 32'b1001);
    check("add_sticky", 32'(sticky_v_o), 32'h1);
    idle(4'(COND_VS));
    check("add_vs", 32'(cond_pass_o), 32'h1);

    // SUB 5 - 5
    step(8'h05, 8'h05, 8'h00, 4'b0001, 1'b1, 1'b1, 4'(COND_AL), 1'b0, 1'b0);
    check("sub_flags", 32'(flags_o), 32'b0110);
    idle(4'(COND_EQ)); check("sub_eq", 32'(cond_pass_o), 32'h1);
    idle(4'(COND_HI)); check("sub_hi", 32'(cond_pass_o), 32'h0);
    idle(4'(COND_LS)); check("sub_ls", 32'(cond_pass_o), 32'h1);

    // AND giving 0x80: N,Z update, C,V held
    step(8'hF0, 8'h80, 8'h80, 4'b0010, 1'b1, 1'b1, 4'(COND_AL), 1'b0, 1'b0);
    check("and_flags", 32'(flags_o), 32'b1010);
    idle(4'(COND_GE)); check("and_ge", 32'(cond_pass_o), 32'h0);
    idle(4'(COND_LT)); check("and_lt", 32'(cond_pass_o), 32'h1);

    // clear, then 5 overflows saturate, then clear with a 6th overflow
    step(8'h00, 8'h00, 8'h00, 4'b0000, 1'b0, 1'b0, 4'(COND_AL), 1'b1, 1'b0);
    check("clr_sticky", 32'(sticky_v_o), 32'h0);
    for (int i = 0; i < 5; i++)
      step(8'h7F, 8'h01, 8'h00, 4'b0000, 1'b1, 1'b1, 4'(COND_VS), 1'b0, 1'b0);
`ifdef ALU_OVF_COUNT_EN
    check("sat_count", 32'(ovf_count_o), 32'h3);
`endif
    step(8'h7F, 8'h01, 8'h00, 4'b0000, 1'b1, 1'b1, 4'(COND_VS), 1'b1, 1'b0);
    check("clr_set_sticky", 32'(sticky_v_o), 32'h1);
`ifdef ALU_OVF_COUNT_EN
    check("clr_set_count", 32'(ovf_count_o), 32'h1);
`endif

    // valid without setflags: nothing changes
    step(8'h01, 8'h01, 8'h00, 4'b0000, 1'b1, 1'b1, 4'(COND_AL), 1'b1, 1'b0);
    step(8'h7F, 8'h01, 8'h00, 4'b0000, 1'b1, 1'b0, 4'(COND_AL), 1'b0, 1'b0);
    check("nosf_flags", 32'(flags_o), 32'b0000);
    check("nosf_sticky", 32'(sticky_v_o), 32'h0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [3:0] ctl;
      ctl = 4'($urandom_range(0, 15));
      step(8'($urandom), 8'($urandom), 8'($urandom_range(0, 3) == 0 ? 0 : $urandom),
           ctl, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
           4'($urandom), 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 63) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
